phase_controller: RTL and testbench

PHASE_CONTROLLER -- requirements
Module: phase_controller

---
 rtl/phase_controller.sv | 155 +++++++++++++++
 tb/tb_phase_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_controller.sv
// Sequences the BOX -> THRESH -> OUTPUT pipeline phases, with a per-stage watchdog
// and a saturating cycle counter that restarts on every BOX entry.
module phase_controller #(
  parameter int unsigned TIMEOUT_BITS = 20,
  parameter bit          AUTO_REPEAT  = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        box_finished,
  input  logic        threshold_finished,
  input  logic        output_finished,
  output logic [2:0]  global_state,
  output logic        stage_start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StBox    = 3'd1,
    StThresh = 3'd2,
    StOutput = 3'd3,
    StDone   = 3'd4,
    StError  = 3'd7
  } state_e;

  localparam logic [TIMEOUT_BITS-1:0] WdMax  = '1;
  // Leaving on this count means the counter reaches all-ones on the same edge.
  localparam logic [TIMEOUT_BITS-1:0] WdLast = WdMax - TIMEOUT_BITS'(1);

  state_e                  state_q, state_d;
  logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
  logic [31:0]             cc_q, cc_d;
  logic                    stage_start_q, stage_start_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic stage_fin;
  logic advance;
  logic timeout;
  logic in_stage;
  logic entering;

  function automatic logic is_stage(input state_e s);
    return (s == StBox) || (s == StThresh) || (s == StOutput);
  endfunction

  // Only the current stage's finished input matters.
  always_comb begin
    stage_fin = 1'b0;
    unique case (state_q)
      StBox:    stage_fin = box_finished;
      StThresh: stage_fin = threshold_finished;
      StOutput: stage_fin = output_finished;
      default:  stage_fin = 1'b0;
    endcase
  end

  // A level left high by the previous stage must not advance on the entry cycle.
  assign advance  = stage_fin & ~stage_start_q;
  assign timeout  = (wd_q == WdLast) & ~advance;
  assign in_stage = is_stage(state_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StBox;
      end
      StBox: begin
        if (advance)      state_d = StThresh;
        else if (timeout) state_d = StError;
      end
      StThresh: begin
        if (advance)      state_d = StOutput;
        else if (timeout) state_d = StError;
      end
      StOutput: begin
        if (advance)      state_d = StDone;
        else if (timeout) state_d = StError;
      end
      StDone: begin
        state_d = AUTO_REPEAT ? StBox : StIdle;
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign entering = is_stage(state_d) && (state_d != state_q);

  always_comb begin
    wd_d = wd_q;
    if (entering) begin
      wd_d = '0;
    end else if (in_stage) begin
      wd_d = wd_q + TIMEOUT_BITS'(1);
    end else begin
      wd_d = '0;
    end
  end

  always_comb begin
    cc_d = cc_q;
    if ((state_d == StBox) && (state_q != StBox)) begin
      cc_d = '0;
    end else if (in_stage && (cc_q != 32'hFFFF_FFFF)) begin
      cc_d = cc_q + 32'd1;
    end
  end

  // Outputs are registered from the next state so they line up with global_state.
  always_comb begin
    stage_start_d = entering;
    busy_d        = is_stage(state_d);
    done_d        = (state_d == StDone);
    error_d       = (state_d == StError);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      wd_q          <= '0;
      cc_q          <= '0;
      stage_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      cc_q          <= cc_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign global_state = state_q;
  assign stage_start  = stage_start_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign cycle_count  = cc_q;

endmodule

// File: tb/tb_phase_controller.sv
// Scoreboard bench for phase_controller: stimulus schedules expected phase transitions,
// a negedge monitor matches them and checks per-cycle output relationships.
module tb_phase_controller;

  localparam logic [2:0] SIdle = 3'd0;
  localparam logic [2:0] SBox  = 3'd1;
  localparam logic [2:0] SThr  = 3'd2;
  localparam logic [2:0] SOut  = 3'd3;
  localparam logic [2:0] SDone = 3'd4;
  localparam logic [2:0] SErr  = 3'd7;

  typedef struct packed {
    int unsigned cyc;
    logic [2:0]  st;
    logic        ss;
    logic        dn;
    logic [31:0] cc;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start   [2];
  logic        box_fin [2];
  logic        thr_fin [2];
  logic        out_fin [2];
  logic [2:0]  gs      [2];
  logic        ss      [2];
  logic        bz      [2];
  logic        dn      [2];
  logic        er      [2];
  logic [31:0] cc      [2];

  int unsigned cyc      = 0;
  logic        rst_prev = 1'b0;
  logic        mon_en   = 1'b0;
  int          checks   = 0;
  int          errors   = 0;
  int          done_cnt [2];
  logic [2:0]  prev_gs  [2];
  logic [31:0] prev_cc  [2];
  ev_t         q0 [$];
  ev_t         q1 [$];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_prev <= reset;
  end

  phase_controller #(.TIMEOUT_BITS(4), .AUTO_REPEAT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start[0]),
    .box_finished(box_fin[0]), .threshold_finished(thr_fin[0]),
    .output_finished(out_fin[0]), .global_state(gs[0]), .stage_start(ss[0]),
    .busy(bz[0]), .done(dn[0]), .error(er[0]), .cycle_count(cc[0])
  );

  phase_controller #(.TIMEOUT_BITS(4), .AUTO_REPEAT(1'b1)) dut1 (
    .clock(clock), .reset(reset), .start(start[1]),
    .box_finished(box_fin[1]), .threshold_finished(thr_fin[1]),
    .output_finished(out_fin[1]), .global_state(gs[1]), .stage_start(ss[1]),
    .busy(bz[1]), .done(dn[1]), .error(er[1]), .cycle_count(cc[1])
  );

  task automatic chk(input int d, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0d, expected %0d (cycle %0d)", d, name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int unsigned at, input logic [2:0] st,
                      input logic [31:0] ccv);
    ev_t e;
    e.cyc = at;
    e.st  = st;
    e.ss  = (st == SBox) || (st == SThr) || (st == SOut);
    e.dn  = (st == SDone);
    e.cc  = ccv;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_cycle(input int d);
    logic        changed;
    logic        entered;
    logic        prev_busy;
    logic [31:0] exp_cc;
    ev_t         e;
    changed = (gs[d] !== prev_gs[d]);
    entered = changed && (gs[d] inside {SBox, SThr, SOut});
    chk(d, "busy", 32'(bz[d]), 32'(gs[d] inside {SBox, SThr, SOut}));
    chk(d, "done", 32'(dn[d]), 32'(gs[d] == SDone));
    chk(d, "error", 32'(er[d]), 32'(gs[d] == SErr));
    chk(d, "stage_start", 32'(ss[d]), 32'(entered));
    if (dn[d] === 1'b1) done_cnt[d]++;
    if (!rst_prev) begin
      prev_busy = prev_gs[d] inside {SBox, SThr, SOut};
      if (entered && (gs[d] == SBox))            exp_cc = 32'd0;
      else if (prev_busy && (prev_cc[d] != '1))  exp_cc = prev_cc[d] + 32'd1;
      else                                       exp_cc = prev_cc[d];
      chk(d, "cycle_count_step", cc[d], exp_cc);
    end
    if (changed) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL dut%0d unscheduled_transition: got state %0d, expected none (cycle %0d)",
                 d, gs[d], cyc);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk(d, "event_cycle", cyc, e.cyc);
        chk(d, "event_state", 32'(gs[d]), 32'(e.st));
        chk(d, "event_stage_start", 32'(ss[d]), 32'(e.ss));
        chk(d, "event_done", 32'(dn[d]), 32'(e.dn));
        chk(d, "event_cycle_count", cc[d], e.cc);
      end
    end
  endtask

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (mon_en) check_cycle(d);
      prev_gs[d] = gs[d];
      prev_cc[d] = cc[d];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_fin(input int d, input int which, input logic v);
    case (which)
      0:       box_fin[d] = v;
      1:       thr_fin[d] = v;
      default: out_fin[d] = v;
    endcase
  endtask

  // Raise the current stage's finished input wait_n cycles into the stage.
  task automatic stage(input int d, input int which, input int wait_n, input logic [2:0] nxt,
                       input int unsigned b);
    tick(wait_n);
    set_fin(d, which, 1'b1);
    push(d, cyc + 1, nxt, cyc + 1 - b);
    tick(1);
    set_fin(d, which, 1'b0);
  endtask

  initial begin
    int unsigned b;
    int unsigned t;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; box_fin[d] = 1'b0; thr_fin[d] = 1'b0; out_fin[d] = 1'b0;
      done_cnt[d] = 0;
    end
    start[0] = 1'b1;  // held through reset; must be ignored until reset falls
    tick(3);
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_state", 32'(gs[d]), 32'd0);
      chk(d, "rst_stage_start", 32'(ss[d]), 32'd0);
      chk(d, "rst_busy", 32'(bz[d]), 32'd0);
      chk(d, "rst_done", 32'(dn[d]), 32'd0);
      chk(d, "rst_error", 32'(er[d]), 32'd0);
      chk(d, "rst_cycle_count", cc[d], 32'd0);
    end
    mon_en = 1'b1;

    // Nominal pass: each finished 10 cycles after its stage_start.
    reset = 1'b0;
    push(0, cyc + 1, SBox, 32'd0);
    tick(1);
    start[0] = 1'b0;
    b = cyc;
    stage(0, 0, 10, SThr, b);
    stage(0, 1, 10, SOut, b);
    stage(0, 2, 10, SDone, b);
    chk(0, "nominal_cc_at_done", cc[0], 32'd33);
    chk(0, "nominal_done_pulse", 32'(dn[0]), 32'd1);
    push(0, cyc + 1, SIdle, 32'd33);
    tick(3);

    // Stale box_finished held from reset: BOX lasts exactly two cycles.
    box_fin[0] = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    start[0] = 1'b1;
    push(0, cyc + 1, SBox, 32'd0);
    tick(1);
    start[0] = 1'b0;
    b = cyc;
    push(0, b + 2, SThr, 32'd2);
    tick(2);
    box_fin[0] = 1'b0;
    chk(0, "stale_in_thresh", 32'(gs[0]), 32'(SThr));

    // Reset in the middle of OUTPUT, then restart.
    stage(0, 1, 3, SOut, b);
    tick(2);
    reset = 1'b1;
    push(0, cyc + 1, SIdle, 32'd0);
    tick(1);
    reset = 1'b0;
    chk(0, "midreset_busy", 32'(bz[0]), 32'd0);
    chk(0, "midreset_cc", cc[0], 32'd0);
    start[0] = 1'b1;
    push(0, cyc + 1, SBox, 32'd0);
    tick(1);
    start[0] = 1'b0;
    b = cyc;

    // THRESH never finishes: ERROR 15 cycles after THRESH entry, sticky.
    stage(0, 0, 2, SThr, b);
    t = cyc;
    push(0, t + 15, SErr, t + 15 - b);
    tick(16);
    chk(0, "timeout_state", 32'(gs[0]), 32'(SErr));
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    tick(3);
    chk(0, "error_sticky_state", 32'(gs[0]), 32'(SErr));
    chk(0, "error_sticky_flag", 32'(er[0]), 32'd1);

    // Auto-repeat: box_finished lands as the watchdog hits its last count.
    start[1] = 1'b1;
    push(1, cyc + 1, SBox, 32'd0);
    tick(1);
    start[1] = 1'b0;
    b = cyc;
    stage(1, 0, 14, SThr, b);
    stage(1, 1, 10, SOut, b);
    stage(1, 2, 10, SDone, b);
    push(1, cyc + 1, SBox, 32'd0);
    tick(1);
    b = cyc;
    stage(1, 0, 10, SThr, b);
    stage(1, 1, 10, SOut, b);
    stage(1, 2, 10, SDone, b);
    chk(1, "repeat_cc_at_done", cc[1], 32'd33);
    push(1, cyc + 1, SBox, 32'd0);
    tick(1);
    b = cyc;
    // Left alone, the third BOX pass times out.
    push(1, b + 15, SErr, 32'd15);
    tick(17);

    reset = 1'b1;
    push(0, cyc + 1, SIdle, 32'd0);
    push(1, cyc + 1, SIdle, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    chk(0, "done_pulses", 32'(done_cnt[0]), 32'd1);
    chk(1, "done_pulses", 32'(done_cnt[1]), 32'd2);
    chk(0, "pending_events", 32'(q0.size()), 32'd0);
    chk(1, "pending_events", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
